// File: rtl/ym3438_timers.sv
// ---------------------------------------------------------------------------
// ym3438_timers
//
// Timer A / Timer B block of the YM3438 (OPN2) sound chip.
//
// Timer A is a 10-bit up-counter, Timer B an 8-bit up-counter clocked through
// a free-running 4-bit prescaler. Both count on the per-sample tick strobe and
// reload from their programmed value on overflow. Each overflow produces a
// one-MCLK event pulse, can set a sticky flag, and the flags are ORed into
// the interrupt request. A Timer A overflow also produces the channel 3 CSM
// key-on pulse when the channel 3 mode is CSM.
//
// Ports
//   MCLK      in   1   master clock, all state updates on its rising edge
//   IC        in   1   synchronous active-low reset
//   timer_ed  in   1   tick strobe, one MCLK wide, once per sample
//   ta_val    in  10   Timer A reload value
//   tb_val    in   8   Timer B reload value
//   load_a/b  in   1   run levels; 0 keeps the counter preloaded
//   en_a/b    in   1   allow an overflow to set the sticky flag
//   rst_a/b   in   1   flag-clear strobes, one MCLK wide
//   csm_mode  in   2   channel 3 mode, 2'b10 = CSM
//   timer_a/b out  1   sticky overflow flags
//   ovf_a/b   out  1   overflow event pulses, one MCLK each
//   irq       out  1   timer_a | timer_b
//   csm_key   out  1   CSM key-on pulse, coincident with ovf_a
//
// Handshake: there is no valid/ready traffic in this block. timer_ed and
// rst_a/rst_b are single-cycle strobes sampled on the rising MCLK edge; all
// other inputs are levels sampled on the same edge.
// ---------------------------------------------------------------------------
module ym3438_timers (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       timer_ed,
    input  logic [9:0] ta_val,
    input  logic [7:0] tb_val,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       en_a,
    input  logic       en_b,
    input  logic       rst_a,
    input  logic       rst_b,
    input  logic [1:0] csm_mode,
    output logic       timer_a,
    output logic       timer_b,
    output logic       ovf_a,
    output logic       ovf_b,
    output logic       irq,
    output logic       csm_key
);

    localparam logic [9:0] CNT_A_MAX = 10'h3FF;
    localparam logic [7:0] CNT_B_MAX = 8'hFF;
    localparam logic [3:0] PRE_B_MAX = 4'hF;
    localparam logic [1:0] MODE_CSM  = 2'b10;

    // State registers
    logic [9:0] r_cnt_a;
    logic [7:0] r_cnt_b;
    logic [3:0] r_pre_b;
    logic       r_ovf_a;
    logic       r_ovf_b;
    logic       r_timer_a;
    logic       r_timer_b;
    logic       r_csm_key;

    // Next-state values
    logic [9:0] w_cnt_a_nxt;
    logic [7:0] w_cnt_b_nxt;
    logic [3:0] w_pre_b_nxt;
    logic       w_ovf_a_nxt;
    logic       w_ovf_b_nxt;
    logic       w_timer_a_nxt;
    logic       w_timer_b_nxt;
    logic       w_csm_key_nxt;

    // -----------------------------------------------------------------------
    // Timer A: preload while stopped, count while running, reload on wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        w_cnt_a_nxt = r_cnt_a;
        w_ovf_a_nxt = 1'b0;
        if (timer_ed) begin
            if (!load_a) begin
                w_cnt_a_nxt = ta_val;
            end else if (r_cnt_a == CNT_A_MAX) begin
                w_cnt_a_nxt = ta_val;
                w_ovf_a_nxt = 1'b1;
            end else begin
                w_cnt_a_nxt = r_cnt_a + 10'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Timer B: the prescaler runs on every tick regardless of load_b, so the
    // first counter step after starting depends on where the prescaler is.
    // While stopped the counter is preloaded on every tick, not only on
    // prescaler wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        w_pre_b_nxt = r_pre_b;
        w_cnt_b_nxt = r_cnt_b;
        w_ovf_b_nxt = 1'b0;
        if (timer_ed) begin
            w_pre_b_nxt = r_pre_b + 4'd1;
            if (!load_b) begin
                w_cnt_b_nxt = tb_val;
            end else if (r_pre_b == PRE_B_MAX) begin
                if (r_cnt_b == CNT_B_MAX) begin
                    w_cnt_b_nxt = tb_val;
                    w_ovf_b_nxt = 1'b1;
                end else begin
                    w_cnt_b_nxt = r_cnt_b + 8'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky flags: an enabled overflow sets the flag on the same edge the
    // event pulse rises, and takes priority over a coincident clear.
    // en_x only gates setting; it never clears an existing flag.
    // -----------------------------------------------------------------------
    always_comb begin
        w_timer_a_nxt = r_timer_a;
        w_timer_b_nxt = r_timer_b;
        if (w_ovf_a_nxt && en_a) begin
            w_timer_a_nxt = 1'b1;
        end else if (rst_a) begin
            w_timer_a_nxt = 1'b0;
        end
        if (w_ovf_b_nxt && en_b) begin
            w_timer_b_nxt = 1'b1;
        end else if (rst_b) begin
            w_timer_b_nxt = 1'b0;
        end
    end

    // CSM key-on follows every Timer A overflow in CSM mode, independent of en_a.
    always_comb begin
        w_csm_key_nxt = w_ovf_a_nxt && (csm_mode == MODE_CSM);
    end

    // -----------------------------------------------------------------------
    // Register update. Reset discards any count in progress and leaves the
    // prescaler at zero, so the first tick after release sees pre_b == 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (!IC) begin
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_pre_b   <= '0;
            r_ovf_a   <= 1'b0;
            r_ovf_b   <= 1'b0;
            r_timer_a <= 1'b0;
            r_timer_b <= 1'b0;
            r_csm_key <= 1'b0;
        end else begin
            r_cnt_a   <= w_cnt_a_nxt;
            r_cnt_b   <= w_cnt_b_nxt;
            r_pre_b   <= w_pre_b_nxt;
            r_ovf_a   <= w_ovf_a_nxt;
            r_ovf_b   <= w_ovf_b_nxt;
            r_timer_a <= w_timer_a_nxt;
            r_timer_b <= w_timer_b_nxt;
            r_csm_key <= w_csm_key_nxt;
        end
    end

    assign timer_a = r_timer_a;
    assign timer_b = r_timer_b;
    assign ovf_a   = r_ovf_a;
    assign ovf_b   = r_ovf_b;
    assign csm_key = r_csm_key;
    assign irq     = r_timer_a | r_timer_b;

endmodule

// File: tb/tb_ym3438_timers.sv
// ---------------------------------------------------------------------------
// tb_ym3438_timers
//
// Directed bench for ym3438_timers. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the following rising edge. Expected
// values are hand-computed for each step.
// ---------------------------------------------------------------------------
module tb_ym3438_timers;

    logic       MCLK;
    logic       IC;
    logic       timer_ed;
    logic [9:0] ta_val;
    logic [7:0] tb_val;
    logic       load_a;
    logic       load_b;
    logic       en_a;
    logic       en_b;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] csm_mode;
    logic       timer_a;
    logic       timer_b;
    logic       ovf_a;
    logic       ovf_b;
    logic       irq;
    logic       csm_key;

    int checks   = 0;
    int failures = 0;

    ym3438_timers dut (
        .MCLK     (MCLK),
        .IC       (IC),
        .timer_ed (timer_ed),
        .ta_val   (ta_val),
        .tb_val   (tb_val),
        .load_a   (load_a),
        .load_b   (load_b),
        .en_a     (en_a),
        .en_b     (en_b),
        .rst_a    (rst_a),
        .rst_b    (rst_b),
        .csm_mode (csm_mode),
        .timer_a  (timer_a),
        .timer_b  (timer_b),
        .ovf_a    (ovf_a),
        .ovf_b    (ovf_b),
        .irq      (irq),
        .csm_key  (csm_key)
    );

    // Clock / reset block
    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // One MCLK edge with the given tick strobe; returns 1 ns after the edge.
    task automatic step(input logic ed);
        timer_ed = ed;
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        IC       = 1'b0;
        timer_ed = 1'b0;
        ta_val   = '0;
        tb_val   = '0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        csm_mode = 2'b00;

        // Reset state
        step(1'b1);
        step(1'b1);
        chk("rst_timer_a", 32'(timer_a), 0);
        chk("rst_timer_b", 32'(timer_b), 0);
        chk("rst_ovf_a",   32'(ovf_a),   0);
        chk("rst_ovf_b",   32'(ovf_b),   0);
        chk("rst_irq",     32'(irq),     0);
        chk("rst_csm_key", 32'(csm_key), 0);
        chk("rst_cnt_a",   32'(dut.r_cnt_a), 0);
        chk("rst_cnt_b",   32'(dut.r_cnt_b), 0);

        // Timer A basic overflow from 1020
        IC = 1'b1; ta_val = 10'd1020; en_a = 1'b1; load_a = 1'b0;
        step(1'b1);
        chk("a_preload", 32'(dut.r_cnt_a), 1020);
        load_a = 1'b1;
        step(1'b1);
        chk("a_cnt1021", 32'(dut.r_cnt_a), 1021);
        step(1'b1);
        chk("a_cnt1022", 32'(dut.r_cnt_a), 1022);
        step(1'b1);
        chk("a_cnt1023", 32'(dut.r_cnt_a), 1023);
        chk("a_no_ovf_yet", 32'(ovf_a), 0);
        step(1'b1);
        chk("a_ovf",      32'(ovf_a),   1);
        chk("a_flag",     32'(timer_a), 1);
        chk("a_irq",      32'(irq),     1);
        chk("a_reload",   32'(dut.r_cnt_a), 1020);
        chk("a_no_csm",   32'(csm_key), 0);
        step(1'b0);
        chk("a_ovf_one_cycle", 32'(ovf_a), 0);
        chk("a_flag_sticky",   32'(timer_a), 1);
        chk("a_hold_no_tick",  32'(dut.r_cnt_a), 1020);

        // Clear, then set and clear coincide: set wins
        rst_a = 1'b1;
        step(1'b0);
        rst_a = 1'b0;
        chk("a_cleared",     32'(timer_a), 0);
        chk("a_cleared_irq", 32'(irq),     0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        rst_a = 1'b1;
        step(1'b1);
        chk("a_set_wins_ovf",  32'(ovf_a),   1);
        chk("a_set_wins_flag", 32'(timer_a), 1);
        step(1'b0);
        rst_a = 1'b0;
        chk("a_rst_alone",     32'(timer_a), 0);
        chk("a_rst_alone_irq", 32'(irq),     0);
        chk("a_rst_alone_tb",  32'(timer_b), 0);

        // Reload value change takes effect at next reload only
        ta_val = 10'd1022;
        step(1'b1);
        chk("a_chg_no_reload", 32'(dut.r_cnt_a), 1021);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        chk("a_chg_ovf",    32'(ovf_a), 1);
        chk("a_chg_reload", 32'(dut.r_cnt_a), 1022);
        rst_a = 1'b1;
        step(1'b0);
        rst_a = 1'b0;

        // en_a=0, ta_val=1023: overflow every tick, CSM key follows
        en_a = 1'b0; ta_val = 10'd1023; csm_mode = 2'b10; load_a = 1'b0;
        step(1'b1);
        chk("a_max_preload", 32'(dut.r_cnt_a), 1023);
        load_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            chk("a_b2b_ovf",  32'(ovf_a),   1);
            chk("a_b2b_csm",  32'(csm_key), 1);
            chk("a_b2b_flag", 32'(timer_a), 0);
            chk("a_b2b_irq",  32'(irq),     0);
        end
        csm_mode = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            chk("a_nocsm_ovf", 32'(ovf_a),   1);
            chk("a_nocsm_key", 32'(csm_key), 0);
        end

        // en_a=0 does not clear an existing flag
        en_a = 1'b1;
        step(1'b1);
        chk("a_en_set", 32'(timer_a), 1);
        en_a = 1'b0;
        step(1'b1);
        chk("a_en_off_keep", 32'(timer_a), 1);
        chk("a_en_off_ovf",  32'(ovf_a),   1);

        // Reset mid-count with a flag set and a tick present
        IC = 1'b0; rst_a = 1'b0;
        step(1'b1);
        chk("ic_timer_a", 32'(timer_a), 0);
        chk("ic_ovf_a",   32'(ovf_a),   0);
        chk("ic_irq",     32'(irq),     0);
        chk("ic_csm_key", 32'(csm_key), 0);
        chk("ic_cnt_a",   32'(dut.r_cnt_a), 0);
        rst_b = 1'b1;
        step(1'b1);
        rst_b = 1'b0;
        chk("ic_hold_cnt_a", 32'(dut.r_cnt_a), 0);

        // After release: Timer A restarts from preload; Timer B from 254
        IC = 1'b1; ta_val = 10'd1021; load_a = 1'b0; en_a = 1'b1; csm_mode = 2'b00;
        tb_val = 8'd254; en_b = 1'b1; load_b = 1'b0;
        step(1'b1);                               // tick 1
        chk("rel_cnt_a", 32'(dut.r_cnt_a), 1021);
        chk("b_preload", 32'(dut.r_cnt_b), 254);
        load_b = 1'b1;
        for (int t = 2; t <= 15; t++) step(1'b1);
        chk("b_wait_prescale", 32'(dut.r_cnt_b), 254);
        step(1'b1);                               // tick 16
        chk("b_cnt255", 32'(dut.r_cnt_b), 255);
        chk("b_no_ovf", 32'(ovf_b), 0);
        for (int t = 17; t <= 31; t++) step(1'b1);
        chk("b_hold255",   32'(dut.r_cnt_b), 255);
        chk("b_no_ovf_31", 32'(ovf_b), 0);
        step(1'b1);                               // tick 32
        chk("b_ovf",     32'(ovf_b),   1);
        chk("b_flag",    32'(timer_b), 1);
        chk("b_irq",     32'(irq),     1);
        chk("b_reload",  32'(dut.r_cnt_b), 254);
        chk("b_ta_flag", 32'(timer_a), 0);
        step(1'b0);
        chk("b_ovf_one_cycle", 32'(ovf_b),   0);
        chk("b_flag_sticky",   32'(timer_b), 1);
        rst_b = 1'b1;
        step(1'b0);
        rst_b = 1'b0;
        chk("b_cleared",     32'(timer_b), 0);
        chk("b_cleared_irq", 32'(irq),     0);

        // load_b=0 preloads on every tick regardless of prescaler
        load_b = 1'b0; tb_val = 8'd100;
        step(1'b1);
        chk("b_stop_preload", 32'(dut.r_cnt_b), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
